// File: rtl/regfile_ab_pkg.sv
// Datapath constants shared by the register bank and the write-register selector.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_ab_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int SP_RESET_DEF = 227;

  // Architectural register indices
  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_array.sv
// Storage for the general-purpose registers: reset init, $zero write drop, two async read ports.
// Latency: writes land on the next rising edge; reads are combinational from storage.
// Backpressure: none, one write accepted every cycle.
module regfile_array
  import regfile_ab_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int                NREG     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem [NREG];

  // Bank update: reset loads $sp with its boot value, writes to $zero are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= (i == REG_SP) ? SP_RESET : '0;
      end
    end else if (we && (waddr != ZERO_IDX)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/regfile_ab.sv
// Register bank with write-through bypass feeding the registered A/B ALU operands.
// Latency: A/B valid one cycle after an ab_load edge; a same-edge write is seen via bypass.
// Backpressure: none, write and capture accepted every cycle.
module regfile_ab
  import regfile_ab_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic              ab_load,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] arr_rd1;
  logic [DATA_W-1:0] arr_rd2;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  regfile_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .we     (reg_write),
    .waddr  (write_reg),
    .wdata  (write_data),
    .raddr1 (read_reg1),
    .raddr2 (read_reg2),
    .rdata1 (arr_rd1),
    .rdata2 (arr_rd2)
  );

  // Operand select: $zero reads as 0, a same-cycle write to the index bypasses storage
  always_comb begin
    op1 = arr_rd1;
    op2 = arr_rd2;
    if (read_reg1 == ZERO_IDX) begin
      op1 = '0;
    end else if (reg_write && (write_reg == read_reg1)) begin
      op1 = write_data;
    end
    if (read_reg2 == ZERO_IDX) begin
      op2 = '0;
    end else if (reg_write && (write_reg == read_reg2)) begin
      op2 = write_data;
    end
  end

  // A/B capture on ab_load, otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      A <= '0;
      B <= '0;
    end else if (ab_load) begin
      A <= op1;
      B <= op2;
    end
  end

endmodule
